lut_sweep: RTL and testbench
============================

# lut_sweep

Parametrised N-input boolean function unit: a 2^N-entry truth table, written through a config port, evaluated two ways. One-cycle registered lookup port, plus a sweep engine that streams every (input vector, output) pair in ascending order over a valid/ready handshake and counts minterms. It is the sequential, programmable successor of the fixed 2-input gate-level `f` blocks. It sits between the lab stimulus generator and the result checker/display logic.

## Interface

- `N`, default 2: number of function inputs; legal range 1..6.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: truth-table write enable.
- `cfg_addr` in N: table entry (input vector) to write.
- `cfg_bit` in 1: output value for `cfg_addr`.
- `eval_x` in N: lookup input vector.
- `eval_s` out 1: registered table value of `eval_x` from the previous cycle.
- `start` in 1: request a full sweep.
- `busy` out 1: sweep in progress.
- `out_valid` out 1: sweep beat valid.
- `out_ready` in 1: sink accepts beat.
- `out_x` out N: input vector of current beat.
- `out_s` out 1: table value for `out_x`.
- `done` out 1: one-cycle pulse after the last beat is accepted.
- `ones_count` out N+1: number of beats with `out_s`=1 in the most recent sweep.

## Operation

- Table: 2^N bits. Reset clears all entries to 0, so the function is constant 0 after reset.
- Write: `cfg_we`=1 in IDLE or DONE writes `cfg_bit` to entry `cfg_addr` at the clock edge. `cfg_we` is ignored in SWEEP; the table is locked during a sweep.
- Lookup: `eval_s` <= table[`eval_x`] every cycle, in any state, including during a sweep.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP when `start`=1. On entry, index=0 and `ones_count`=0.
  - SWEEP: `out_valid`=1, `out_x`=index, `out_s`=table[index].
    - Handshake (valid&ready at edge): add `out_s` to `ones_count`.
    - If index=2^N-1, go to DONE. Otherwise index+1.
    - With `out_ready`=0, `out_x`/`out_s` hold stable.
  - DONE: `done`=1 for exactly one cycle, then IDLE. `start` in DONE is ignored.
- `start` in SWEEP or DONE is ignored; no restart, no queueing.
- `start` and `cfg_we` in the same IDLE cycle: the write lands at that edge, and the sweep sees the updated table.
- `ones_count` holds its final value after DONE until the next accepted `start`. Its width N+1 covers the full count 2^N without wrap.
- Index counter is N bits and never wraps inside a sweep; termination is by the last-index compare.

## Timing

- Reset values: `eval_s`=0, `busy`=0, `out_valid`=0, `out_x`=0, `out_s`=0, `done`=0, `ones_count`=0, state IDLE, table all 0.
- `rst_n` asserted mid-sweep aborts immediately to the reset values. No `done` pulse is produced.
- Lookup latency: 1 cycle.
- `start` sampled at edge t:
  - `busy`=`out_valid`=1 from t+1 with `out_x`=0.
  - `busy` is high exactly while in SWEEP.
- Throughput: one beat per cycle when `out_ready` is held high, with no bubbles.
- With `out_ready` constantly 1, `done` rises 2^N+1 cycles after the `start` edge.
- After the last handshake edge e: `out_valid`=0, `busy`=0, `done`=1 during cycle e+1, `ones_count` final at e+1.
- All outputs are registered; none is combinational from inputs.

## Structure

- Package `lut_sweep_pkg`: state enum (IDLE, SWEEP, DONE) and constant `N_MAX`=6.
- Sub-module `lut_mem`: 2^N x 1 storage with one synchronous write port, one registered read port (lookup) and one combinational read port (sweep). Reset clears storage.
- Top holds the FSM, index counter, `ones_count` and handshake logic.

## Test plan

- Reset, no writes, N=2, `start` with `out_ready`=1 -> beats x=0..3 all s=0, `done` at cycle 5 after start, `ones_count`=0.
- Write table {x=1:1, x=2:1} (XOR), sweep -> s sequence 0,1,1,0, `ones_count`=2. Lookup `eval_x`=2 -> `eval_s`=1 one cycle later.
- Sweep with `out_ready` toggling 1,0,0,1,... -> each beat held stable while not ready, no beat lost or duplicated, `done` only after 4 handshakes.
- `cfg_we` writing x=0:1 during SWEEP -> table unchanged, next sweep still s(0)=0. `start` during SWEEP and DONE -> ignored, exactly one `done` pulse.
- `start`+`cfg_we`(x=3:1) in the same IDLE cycle -> first sweep shows s(3)=1.
- `rst_n` low at beat x=2 -> all outputs 0 asynchronously, table cleared, no `done`. N=6 all-ones table -> `ones_count`=64.

Source files
------------

// File: rtl/lut_sweep_pkg.sv
// Shared types and limits for the lut_sweep programmable truth-table unit.
package lut_sweep_pkg;

  localparam int N_MAX = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/lut_sweep_mem.sv
// 2^N x 1 truth-table storage: one write port, one registered lookup port,
// one combinational port for the sweep engine.
module lut_mem
  import lut_sweep_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_we,
  input  logic [N-1:0] i_waddr,
  input  logic         i_wbit,
  input  logic [N-1:0] i_raddr,
  output logic         o_rdata,
  input  logic [N-1:0] i_caddr,
  output logic         o_cdata
);

  localparam int DEPTH = 1 << N;

  logic [DEPTH-1:0] r_mem;
  logic             r_rdata;

  // Table update and registered lookup; lookup returns the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= {DEPTH{1'b0}};
      r_rdata <= 1'b0;
    end else begin
      if (i_we) begin
        r_mem[i_waddr] <= i_wbit;
      end
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
  assign o_cdata = r_mem[i_caddr];

endmodule

// File: rtl/lut_sweep.sv
// Programmable N-input boolean function: registered lookup plus a sweep engine
// streaming every (x, f(x)) pair over valid/ready and counting minterms.
module lut_sweep
  import lut_sweep_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_cfg_we,
  input  logic [N-1:0] i_cfg_addr,
  input  logic         i_cfg_bit,
  input  logic [N-1:0] i_eval_x,
  output logic         o_eval_s,
  input  logic         i_start,
  output logic         o_busy,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [N-1:0] o_out_x,
  output logic         o_out_s,
  output logic         o_done,
  output logic [N:0]   o_ones_count
);

  localparam logic [N-1:0] LAST_IDX = {N{1'b1}};

  state_t       r_state;
  logic [N-1:0] r_idx;
  logic         r_busy;
  logic         r_valid;
  logic         r_out_s;
  logic         r_done;
  logic [N:0]   r_ones;

  logic         w_we;
  logic [N-1:0] w_next_idx;
  logic         w_cdata;
  logic         w_next_s;

  // Table is locked in SWEEP; the next beat's value bypasses a same-edge write
  // so a start issued together with a write sees the updated entry.
  always_comb begin
    w_we = i_cfg_we && (r_state != ST_SWEEP);
    if (r_state == ST_SWEEP) begin
      w_next_idx = r_idx + N'(1);
    end else begin
      w_next_idx = {N{1'b0}};
    end
    if (w_we && (i_cfg_addr == w_next_idx)) begin
      w_next_s = i_cfg_bit;
    end else begin
      w_next_s = w_cdata;
    end
  end

  lut_mem #(.N(N)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (i_cfg_addr),
    .i_wbit  (i_cfg_bit),
    .i_raddr (i_eval_x),
    .o_rdata (o_eval_s),
    .i_caddr (w_next_idx),
    .o_cdata (w_cdata)
  );

  // Sweep FSM with registered handshake outputs and minterm counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= {N{1'b0}};
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_out_s <= 1'b0;
      r_done  <= 1'b0;
      r_ones  <= {(N+1){1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= ST_SWEEP;
            r_idx   <= {N{1'b0}};
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_out_s <= w_next_s;
            r_ones  <= {(N+1){1'b0}};
          end
        end
        ST_SWEEP: begin
          if (i_out_ready) begin
            r_ones <= r_ones + {{N{1'b0}}, r_out_s};
            if (r_idx == LAST_IDX) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= w_next_idx;
              r_out_s <= w_next_s;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_out_valid  = r_valid;
  assign o_out_x      = r_idx;
  assign o_out_s      = r_out_s;
  assign o_done       = r_done;
  assign o_ones_count = r_ones;

endmodule

// File: tb/tb_lut_sweep.sv
// Self-checking bench for lut_sweep: lookup vector table, model-driven sweeps,
// handshake/lock/reset corner cases, and an N=6 all-ones sweep.
module tb_lut_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cfg_we, cfg_bit, eval_s, start, busy, out_valid, out_ready, out_s, done;
  logic [1:0] cfg_addr, eval_x, out_x;
  logic [2:0] ones_count;

  logic       cfg_we6, cfg_bit6, eval_s6, start6, busy6, out_valid6, out_ready6, out_s6, done6;
  logic [5:0] cfg_addr6, eval_x6, out_x6;
  logic [6:0] ones6;

  lut_sweep #(.N(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_bit(cfg_bit),
    .i_eval_x(eval_x), .o_eval_s(eval_s), .i_start(start), .o_busy(busy),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_x(out_x), .o_out_s(out_s),
    .o_done(done), .o_ones_count(ones_count)
  );

  lut_sweep #(.N(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .i_cfg_we(cfg_we6), .i_cfg_addr(cfg_addr6), .i_cfg_bit(cfg_bit6),
    .i_eval_x(eval_x6), .o_eval_s(eval_s6), .i_start(start6), .o_busy(busy6),
    .o_out_valid(out_valid6), .i_out_ready(out_ready6), .o_out_x(out_x6), .o_out_s(out_s6),
    .o_done(done6), .o_ones_count(ones6)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit mtbl [4];

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic       wbit;
    logic [1:0] ex;
    logic       exp_s;
  } lvec_t;
  lvec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 ready always high, 1 pattern 1,0,0,..., 2 random
  task automatic run_sweep(input int rmode, input bit noise, input bit pre_we,
                           input logic [1:0] pre_addr, input bit pre_bit);
    int   exp_x [$];
    bit   exp_s [$];
    int   exp_ones, got, cyc;
    logic [1:0] last_ev;
    bit   ev_ok;
    start = 1'b1;
    if (pre_we) begin
      cfg_we = 1'b1; cfg_addr = pre_addr; cfg_bit = pre_bit;
      mtbl[pre_addr] = pre_bit;
    end
    tick;
    start = 1'b0; cfg_we = 1'b0;
    exp_ones = 0;
    for (int x = 0; x < 4; x++) begin
      exp_x.push_back(x);
      exp_s.push_back(mtbl[x]);
      exp_ones += int'(mtbl[x]);
    end
    chk("start_busy", busy, 1);
    chk("start_x", out_x, 0);
    got = 0; cyc = 0; ev_ok = 1'b0; last_ev = 2'd0;
    while (got < 4 && cyc < 64) begin
      if (ev_ok) chk("sweep_eval", eval_s, mtbl[last_ev]);
      chk("beat_valid", out_valid, 1);
      chk("beat_busy", busy, 1);
      chk("beat_x", out_x, exp_x[got]);
      chk("beat_s", out_s, exp_s[got]);
      chk("no_early_done", done, 0);
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (noise) begin
        start = 1'b1; cfg_we = 1'b1;
        cfg_addr = 2'($urandom_range(0, 3));
        cfg_bit = ~mtbl[cfg_addr];
      end
      last_ev = 2'($urandom_range(0, 3));
      eval_x = last_ev; ev_ok = 1'b1;
      tick;
      if (out_ready) got++;
      cyc++;
    end
    chk("sweep_bounded", (got == 4), 1);
    cfg_we = 1'b0;
    start = noise;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", out_valid, 0);
    chk("ones_count", ones_count, exp_ones);
    tick;
    start = 1'b0;
    chk("done_once", done, 0);
    chk("idle_busy", busy, 0);
    chk("ones_hold", ones_count, exp_ones);
    tick;
    chk("idle_quiet", {done, busy, out_valid}, 0);
    chk("ones_hold2", ones_count, exp_ones);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int seen;
    rst_n = 1'b0;
    {cfg_we, cfg_bit, start, out_ready} = 4'd0;
    cfg_addr = 2'd0; eval_x = 2'd0;
    {cfg_we6, cfg_bit6, start6, out_ready6} = 4'd0;
    cfg_addr6 = 6'd0; eval_x6 = 6'd0;
    for (int i = 0; i < 4; i++) mtbl[i] = 1'b0;

    vt[0] = '{1'b1, 2'd1, 1'b1, 2'd1, 1'b0};
    vt[1] = '{1'b1, 2'd2, 1'b1, 2'd1, 1'b1};
    vt[2] = '{1'b0, 2'd0, 1'b0, 2'd2, 1'b1};
    vt[3] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
    vt[4] = '{1'b0, 2'd0, 1'b0, 2'd3, 1'b0};
    vt[5] = '{1'b1, 2'd3, 1'b1, 2'd3, 1'b0};
    vt[6] = '{1'b1, 2'd3, 1'b0, 2'd3, 1'b1};
    vt[7] = '{1'b0, 2'd0, 1'b0, 2'd3, 1'b0};

    tick; tick;
    chk("rst_eval_s", eval_s, 0);
    chk("rst_busy_valid_done", {busy, out_valid, done}, 0);
    chk("rst_out_x_s", {out_x, out_s}, 0);
    chk("rst_ones", ones_count, 0);
    chk("rst_n6", {busy6, out_valid6, done6, ones6}, 0);
    rst_n = 1'b1;
    tick;

    // constant-0 function after reset
    run_sweep(0, 1'b0, 1'b0, 2'd0, 1'b0);

    // lookup table: same-edge write returns the old value
    for (int i = 0; i < 8; i++) begin
      cfg_we = vt[i].we; cfg_addr = vt[i].addr; cfg_bit = vt[i].wbit; eval_x = vt[i].ex;
      if (vt[i].we) mtbl[vt[i].addr] = vt[i].wbit;
      tick;
      chk($sformatf("lookup%0d", i), eval_s, vt[i].exp_s);
    end
    cfg_we = 1'b0;

    run_sweep(0, 1'b0, 1'b0, 2'd0, 1'b0);   // XOR: 0,1,1,0
    run_sweep(1, 1'b0, 1'b0, 2'd0, 1'b0);   // throttled
    run_sweep(0, 1'b1, 1'b0, 2'd0, 1'b0);   // locked table, ignored starts
    run_sweep(0, 1'b0, 1'b0, 2'd0, 1'b0);   // table still unchanged
    run_sweep(0, 1'b0, 1'b1, 2'd3, 1'b1);   // start + write x=3 same cycle

    for (int it = 0; it < 6; it++) begin
      for (int w = 0; w < 4; w++) begin
        if ($urandom_range(0, 1) == 1) begin
          cfg_we = 1'b1; cfg_addr = 2'(w); cfg_bit = 1'($urandom_range(0, 1));
          mtbl[w] = cfg_bit;
          tick;
        end
      end
      cfg_we = 1'b0;
      for (int k = 0; k < 4; k++) begin
        eval_x = 2'($urandom_range(0, 3));
        tick;
        chk("rand_lookup", eval_s, mtbl[eval_x]);
      end
      run_sweep(2, 1'(it % 2), 1'b0, 2'd0, 1'b0);
    end

    // fill table with ones, then reset at beat x=2
    cfg_we = 1'b1; cfg_bit = 1'b1;
    for (int w = 0; w < 4; w++) begin
      cfg_addr = 2'(w); tick;
    end
    cfg_we = 1'b0; eval_x = 2'd1;
    start = 1'b1; out_ready = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    chk("pre_rst_x", out_x, 2);
    chk("pre_rst_ones", ones_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", {busy, out_valid, done}, 0);
    chk("async_rst_data", {out_x, out_s, eval_s}, 0);
    chk("async_rst_ones", ones_count, 0);
    for (int i = 0; i < 4; i++) mtbl[i] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    tick;
    chk("post_rst_no_done", done, 0);
    eval_x = 2'd3;
    tick;
    chk("post_rst_eval", eval_s, 0);
    run_sweep(0, 1'b0, 1'b0, 2'd0, 1'b0);   // table cleared

    // N=6 all-ones table
    cfg_we6 = 1'b1; cfg_bit6 = 1'b1;
    for (int a = 0; a < 64; a++) begin
      cfg_addr6 = 6'(a); tick;
    end
    cfg_we6 = 1'b0;
    start6 = 1'b1; out_ready6 = 1'b1;
    tick;
    start6 = 1'b0;
    n = 0; seen = 0;
    while (!done6 && n < 200) begin
      if (out_valid6 && out_x6 == 6'(seen) && out_s6) seen++;
      tick;
      n++;
    end
    chk("n6_done_cycle", n + 1, 65);
    chk("n6_beats", seen, 64);
    chk("n6_ones", ones6, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
